// File: rtl/stdp_update_sched_if.sv
// Request/acknowledge, update-broadcast and readout bundle of the STDP update scheduler.
// master = synapse timing units / weight consumers, slave = scheduler.
interface stdp_update_sched_if #(
    parameter int N_SYN    = 4,
    parameter int W_WIDTH  = 8,
    parameter int DT_WIDTH = 8
);
    localparam int IDX_W = (N_SYN > 1) ? $clog2(N_SYN) : 1;

    logic [N_SYN-1:0]          req;
    logic [N_SYN*DT_WIDTH-1:0] dt_flat;
    logic [N_SYN-1:0]          ack;
    logic                      busy;
    logic                      upd_valid;
    logic [IDX_W-1:0]          upd_idx;
    logic [W_WIDTH-1:0]        upd_weight;
    logic [IDX_W-1:0]          rd_sel;
    logic [W_WIDTH-1:0]        rd_weight;

    modport master (
        output req, dt_flat, rd_sel,
        input  ack, busy, upd_valid, upd_idx, upd_weight, rd_weight
    );

    modport slave (
        input  req, dt_flat, rd_sel,
        output ack, busy, upd_valid, upd_idx, upd_weight, rd_weight
    );
endinterface

// File: rtl/stdp_update_sched.sv
// Shared STDP weight-update controller: round-robin grant, shift-based LTP/LTD step, saturating write.
// Latency: grant edge -> CALC edge -> WRITE edge; ack/upd_valid visible the cycle after the WRITE edge.
// Backpressure: one update in flight; requesters hold req until ack, new requests wait for IDLE.
module stdp_update_sched #(
    parameter int N_SYN     = 4,
    parameter int W_WIDTH   = 8,
    parameter int DT_WIDTH  = 8,
    parameter int W_INIT    = 16,
    parameter int W_MAX     = 255,
    parameter int A_STEP    = 32,
    parameter int TAU_SHIFT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    stdp_update_sched_if.slave   bus
);
    localparam int IDX_W = (N_SYN > 1) ? $clog2(N_SYN) : 1;
    localparam logic [W_WIDTH-1:0]  A_STEP_W = W_WIDTH'(A_STEP);
    localparam logic [W_WIDTH:0]    W_MAX_X  = (W_WIDTH+1)'(W_MAX);
    localparam logic [DT_WIDTH:0]   K_LIMIT  = (DT_WIDTH+1)'(W_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;

    state_t                      state;
    logic [W_WIDTH-1:0]          w_q [N_SYN];
    logic [IDX_W-1:0]            ptr;
    logic [IDX_W-1:0]            idx_q;
    logic signed [DT_WIDTH-1:0]  dt_q;
    logic [W_WIDTH-1:0]          new_q;
    logic [N_SYN-1:0]            ack_q;
    logic                        busy_q;
    logic                        upd_valid_q;
    logic [IDX_W-1:0]            upd_idx_q;
    logic [W_WIDTH-1:0]          upd_weight_q;

    // Round-robin pick: lowest offset from ptr+1 wins; the acked requester is masked
    // for its ack cycle so a still-held req cannot be granted twice.
    logic [N_SYN-1:0] eff_req;
    logic             grant_vld;
    logic [IDX_W-1:0] grant_idx;
    int               cand;

    always_comb begin
        eff_req   = bus.req & ~ack_q;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int i = N_SYN; i >= 1; i--) begin
            cand = (int'(ptr) + i) % N_SYN;
            if (eff_req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
    end

    logic [DT_WIDTH:0]  dt_ext;
    logic [DT_WIDTH:0]  mag;
    logic [DT_WIDTH:0]  k;
    logic [W_WIDTH-1:0] step;
    logic [W_WIDTH-1:0] cur_w;
    logic [W_WIDTH:0]   sum;
    logic [W_WIDTH-1:0] calc_w;

    // |dt| is one bit wider so the most negative dt maps to a positive magnitude.
    always_comb begin
        dt_ext = {dt_q[DT_WIDTH-1], dt_q};
        mag    = dt_q[DT_WIDTH-1] ? (~dt_ext + 1'b1) : dt_ext;
        k      = mag >> TAU_SHIFT;
        step   = (k >= K_LIMIT) ? '0 : (A_STEP_W >> k);
        cur_w  = w_q[idx_q];
        sum    = {1'b0, cur_w} + {1'b0, step};
        calc_w = cur_w;
        if (dt_q[DT_WIDTH-1]) begin
            calc_w = (cur_w < step) ? '0 : (cur_w - step);
        end else if (dt_q != '0) begin
            calc_w = (sum > W_MAX_X) ? W_MAX_X[W_WIDTH-1:0] : sum[W_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            for (int i = 0; i < N_SYN; i++) w_q[i] <= W_WIDTH'(W_INIT);
            ptr          <= IDX_W'(N_SYN - 1);
            idx_q        <= '0;
            dt_q         <= '0;
            new_q        <= '0;
            ack_q        <= '0;
            busy_q       <= 1'b0;
            upd_valid_q  <= 1'b0;
            upd_idx_q    <= '0;
            upd_weight_q <= '0;
        end else begin
            ack_q       <= '0;
            upd_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        idx_q  <= grant_idx;
                        dt_q   <= bus.dt_flat[int'(grant_idx)*DT_WIDTH +: DT_WIDTH];
                        ptr    <= grant_idx;
                        busy_q <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    new_q <= calc_w;
                    state <= WRITE;
                end
                WRITE: begin
                    w_q[idx_q]   <= new_q;
                    ack_q        <= N_SYN'(1) << idx_q;
                    upd_valid_q  <= 1'b1;
                    upd_idx_q    <= idx_q;
                    upd_weight_q <= new_q;
                    busy_q       <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.rd_weight = '0;
        if (int'(bus.rd_sel) < N_SYN) bus.rd_weight = w_q[bus.rd_sel];
    end

    assign bus.ack        = ack_q;
    assign bus.busy       = busy_q;
    assign bus.upd_valid  = upd_valid_q;
    assign bus.upd_idx    = upd_idx_q;
    assign bus.upd_weight = upd_weight_q;
endmodule

// File: tb/tb_stdp_update_sched.sv
// Directed bench for stdp_update_sched: LTP/LTD steps, floor/ceiling, round-robin order, reset abort.
module tb_stdp_update_sched;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    stdp_update_sched_if #(.N_SYN(4), .W_WIDTH(8), .DT_WIDTH(8)) bus ();

    stdp_update_sched #(
        .N_SYN(4), .W_WIDTH(8), .DT_WIDTH(8), .W_INIT(16),
        .W_MAX(255), .A_STEP(32), .TAU_SHIFT(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One isolated update on synapse i; exp_lat > 0 also checks negedges from drive to ack.
    task automatic run_one(input string tag, input int i, input int d, input int exp_w, input int exp_lat);
        int   cyc;
        logic seen;
        @(posedge clk); #1;
        bus.req = 4'(1 << i);
        bus.dt_flat[i*8 +: 8] = 8'(d);
        bus.rd_sel = 2'(i);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus.ack != '0) seen = 1'b1;
        end
        check({tag, "_seen"}, 32'(seen), 1);
        if (exp_lat > 0) check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_ack"}, 32'(bus.ack), 1 << i);
        check({tag, "_vld"}, 32'(bus.upd_valid), 1);
        check({tag, "_idx"}, 32'(bus.upd_idx), i);
        check({tag, "_w"}, 32'(bus.upd_weight), exp_w);
        check({tag, "_rd"}, 32'(bus.rd_weight), exp_w);
        @(posedge clk); #1;
        bus.req = '0;
        @(negedge clk);
        check({tag, "_ack_off"}, 32'(bus.ack), 0);
        check({tag, "_vld_off"}, 32'(bus.upd_valid), 0);
        check({tag, "_idle"}, 32'(bus.busy), 0);
    endtask

    initial begin
        int sat_exp[9] = '{48, 80, 112, 144, 176, 208, 240, 255, 255};
        int rr_idx[5]  = '{0, 1, 2, 3, 0};
        int rr_w[5]    = '{24, 24, 24, 24, 32};
        int n;
        int cyc;

        rst_n       = 1'b0;
        bus.req     = '0;
        bus.dt_flat = '0;
        bus.rd_sel  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rd_sel = 2'(i);
            #1;
            check($sformatf("rst_w%0d", i), 32'(bus.rd_weight), 16);
        end
        check("rst_ack", 32'(bus.ack), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_vld", 32'(bus.upd_valid), 0);
        rst_n = 1'b1;

        // LTP: |dt|=3 -> k=0 -> step 32
        run_one("ltp2", 2, 3, 48, 4);

        // LTD: -5 -> k=1 step 16 -> 0; -1 -> step 32 floors at 0; -128 -> k=32 -> step 0
        run_one("ltd1_a", 1, -5, 0, 0);
        run_one("ltd1_b", 1, -1, 0, 0);
        run_one("ltd1_c", 1, -128, 0, 0);
        run_one("ltd3_big", 3, -128, 16, 0);

        for (int j = 0; j < 9; j++)
            run_one($sformatf("sat0_%0d", j), 0, 1, sat_exp[j], 0);
        run_one("sat0_far", 0, 40, 255, 0);

        // Abort an update in CALC with reset, then all four request with dt=+8 (step 8).
        @(posedge clk); #1;
        bus.req = 4'b1000;
        bus.dt_flat[3*8 +: 8] = 8'd5;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_ack", 32'(bus.ack), 0);
        check("abort_vld", 32'(bus.upd_valid), 0);
        check("abort_busy_off", 32'(bus.busy), 0);
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) bus.dt_flat[i*8 +: 8] = 8'd8;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rd_sel = 2'(i);
            #1;
            check($sformatf("abort_w%0d", i), 32'(bus.rd_weight), 16);
        end
        rst_n = 1'b1;

        n   = 0;
        cyc = 0;
        while (n < 5 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.ack != '0) begin
                check($sformatf("rr%0d_onehot", n), $countones(bus.ack), 1);
                check($sformatf("rr%0d_idx", n), 32'(bus.upd_idx), rr_idx[n]);
                check($sformatf("rr%0d_w", n), 32'(bus.upd_weight), rr_w[n]);
                n++;
            end
        end
        check("rr_count", n, 5);
        bus.req = '0;
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
